asrm_byte_bridge: RTL and testbench
===================================

// Module: asrm_byte_bridge
// PURPOSE
// - Sits between the CPU system bus and a byte-wide memory/peripheral bus.
// - Splits each CPU word access into sequential byte transactions, little-endian.
// - Reassembles read data and reports completion (cpu_ready) or timeout (cpu_error).
// - cpu_size uses the same encoding as the status-register reduced-behaviour bits.
// PARAMETERS
// wordsize  16  CPU data/address width in bits; multiple of 8; 8..64
// timeout   15  max cycles to wait for mem_ack on one byte before aborting (>=1)
// PORTS
// clk          in   1         system clock, all state updates on posedge
// reset        in   1         synchronous, active-low; clears all state when 0
// cpu_req      in   1         start an access; sampled only in IDLE
// cpu_write_en in   1         1 = write, 0 = read; latched with cpu_req
// cpu_size     in   2         00 full word, 01 32-bit, 10 16-bit, 11 8-bit
// cpu_addr     in   wordsize  byte address of the least significant byte
// cpu_data_out in   wordsize  write data, latched with cpu_req
// cpu_data_in  out  wordsize  read data, zero-extended; valid while cpu_ready=1
// cpu_ready    out  1         one-cycle pulse: access finished
// cpu_error    out  1         qualifies cpu_ready: access aborted on timeout
// mem_en       out  1         byte transaction active
// mem_we       out  1         byte write strobe (meaningful only with mem_en)
// mem_addr     out  wordsize  byte address of current transaction
// mem_wdata    out  8         byte write data
// mem_rdata    in   8         byte read data, sampled when mem_ack=1
// mem_ack      in   1         current byte done; may be high the same cycle as mem_en
// BEHAVIOUR
// - Reset (reset=0 at posedge): state IDLE; all outputs, byte index, timeout
//   counter and data registers = 0. Takes effect mid-access too; any
//   partially written word in memory is left as-is (no rollback).
// - Byte count N: 00 -> wordsize/8; 01 -> min(4, wordsize/8);
//   10 -> min(2, wordsize/8); 11 -> 1.
// - IDLE: when cpu_req=1, latch addr/data/we/N, clear read buffer, k=0 -> ACCESS.
//   When cpu_req=0, stay in IDLE.
// - ACCESS: mem_en=1, mem_we=latched we, mem_addr=addr+k (mod 2^wordsize),
//   mem_wdata=data[8k+7:8k].
//   - mem_ack=1: on a read, buffer[8k+7:8k]=mem_rdata; clear timeout counter.
//     If k=N-1 -> DONE, else k=k+1 and stay in ACCESS (next byte in the next cycle).
//   - mem_ack=0: counter+1; reaching timeout -> DONE with error flag set.
// - DONE (one cycle): mem_en=0, cpu_ready=1, cpu_error=flag,
//   cpu_data_in=buffer (bits above 8N are 0; 0 for writes) -> IDLE.
//   cpu_data_in and cpu_error hold their values until the next request is accepted.
// - Latency: with mem_ack tied high, cpu_req at cycle 0 -> ACCESS cycles 1..N
//   -> cpu_ready at cycle N+1. Zero wait states give one byte per cycle.
// - cpu_req is ignored in ACCESS/DONE; the earliest next accept is the cycle after DONE.
// - Address wrap: 0xFFFF + 1 -> 0x0000 (wordsize=16); no carry or error.
// TESTING
// - W16, ack tied 1: write 0xBEEF to 0x0010 size 00 -> bytes EF@0x10, BE@0x11;
//   cpu_ready at cycle 3.
// - W16 read size 00 from 0x0020, mem holds 34,12 -> cpu_data_in=0x1234,
//   cpu_error=0.
// - W32 read size 11 at 0x0003, byte 0xA5 -> one mem transaction; data=0x000000A5.
// - W16, ack delayed 2 cycles per byte -> cpu_ready 7 cycles after req;
//   new cpu_req held during the access is accepted only after DONE.
// - ack never asserted, timeout=15 -> cpu_ready=1, cpu_error=1 after 15 wait
//   cycles; mem_en then drops.
// - reset=0 during byte 2 of a write at 0xFFFF -> next cycle IDLE, outputs 0;
//   the byte at 0x0000 (wrap) is never written.

Source files
------------

// File: rtl/asrm_byte_bridge.sv
// CPU word bus to byte bus bridge: splits each access into little-endian byte
// transactions, reassembles read data, and aborts a byte that waits too long for mem_ack.
module asrm_byte_bridge #(
  parameter int wordsize = 16,
  parameter int timeout  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_write_en,
  input  logic [1:0]          cpu_size,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_ready,
  output logic                cpu_error,
  output logic                mem_en,
  output logic                mem_we,
  output logic [wordsize-1:0] mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack
);

  localparam int NB = wordsize / 8;
  localparam int KW = $clog2(NB) + 1;
  localparam int CW = $clog2(timeout + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [wordsize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdat_q, wdat_d;
  logic [wordsize-1:0] rbuf_q, rbuf_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          wbyte;

  // Index of the final byte for a given size code, clipped to the word width.
  function automatic logic [KW-1:0] last_index(input logic [1:0] sz);
    int n;
    case (sz)
      2'b00:   n = NB;
      2'b01:   n = (NB < 4) ? NB : 4;
      2'b10:   n = (NB < 2) ? NB : 2;
      default: n = 1;
    endcase
    return KW'(n - 1);
  endfunction

  always_comb begin
    wbyte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (KW'(b) == k_q) wbyte = wdat_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rbuf_d  = rbuf_q;
    we_d    = we_q;
    err_d   = err_q;
    k_d     = k_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdat_d  = cpu_data_out;
          we_d    = cpu_write_en;
          last_d  = last_index(cpu_size);
          rbuf_d  = '0;
          err_d   = 1'b0;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            for (int b = 0; b < NB; b++) begin
              if (KW'(b) == k_q) rbuf_d[8*b +: 8] = mem_rdata;
            end
          end
          cnt_d = '0;
          if (k_q == last_q) state_d = S_DONE;
          else               k_d     = k_q + 1'b1;
        end else if (cnt_q == CW'(timeout - 1)) begin
          // This was the last allowed wait cycle; give up on the whole access.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      rbuf_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rbuf_q  <= rbuf_d;
      we_q    <= we_d;
      err_q   <= err_d;
      k_q     <= k_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte bus is only driven during ACCESS so idle and reset both present zeros.
  assign mem_en      = (state_q == S_ACCESS);
  assign mem_we      = mem_en & we_q;
  assign mem_addr    = mem_en ? (addr_q + wordsize'(k_q)) : '0;
  assign mem_wdata   = mem_en ? wbyte : 8'h00;
  assign cpu_ready   = (state_q == S_DONE);
  assign cpu_data_in = rbuf_q;
  assign cpu_error   = err_q;

endmodule

// File: tb/tb_asrm_byte_bridge.sv
// Randomized bench for asrm_byte_bridge: a byte-memory responder plus a word-level
// reference model predicting latency, byte sequence, read data and timeout.
module tb_asrm_byte_bridge;
  localparam int W  = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_write_en = 1'b0;
  logic [1:0]    cpu_size = 2'b00;
  logic [W-1:0]  cpu_addr = '0;
  logic [W-1:0]  cpu_data_out = '0;
  logic [W-1:0]  cpu_data_in;
  logic          cpu_ready, cpu_error;
  logic          mem_en, mem_we;
  logic [W-1:0]  mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  asrm_byte_bridge #(.wordsize(W), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write_en(cpu_write_en),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } txn_t;

  logic [7:0] bus_mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         init_done = 1'b0;
  int         wait_cnt = 0;
  int         ack_mode = 0;   // 0 ack tied high, 1 ack after ack_dly wait cycles, 2 never
  int         ack_dly = 0;
  txn_t       log_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-bus slave: commits handshakes on posedge, drives ack/rdata on negedge.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) bus_mem[16'(i)] <= init_byte(i);
      init_done <= 1'b1;
    end
    if (reset && mem_en && mem_ack) begin
      if (mem_we) bus_mem[mem_addr] <= mem_wdata;
      log_q.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : mem_rdata)});
      wait_cnt <= 0;
    end else if (reset && mem_en) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      mem_rdata = bus_mem[mem_addr];
      mem_ack   = (ack_mode == 0) || (ack_mode == 1 && wait_cnt >= ack_dly);
    end else begin
      mem_rdata = 8'h00;
      mem_ack   = 1'b0;
    end
  end

  task automatic do_access(input bit we, input logic [1:0] sz, input logic [15:0] a,
                           input logic [15:0] d, input int mode, input int dly, input bit hold);
    int          n, lat, cyc, nexp;
    bit          to;
    logic [15:0] exp_rd, ba, sh;
    logic [7:0]  eb;
    n = (sz == 2'b00) ? W/8 : (sz == 2'b01) ? ((W/8 < 4) ? W/8 : 4)
      : (sz == 2'b10) ? ((W/8 < 2) ? W/8 : 2) : 1;
    to   = (mode == 2);
    lat  = to ? TO + 1 : (mode == 1) ? n * (dly + 1) + 1 : n + 1;
    nexp = to ? 0 : n;
    exp_rd = '0;
    if (!we && !to)
      for (int i = 0; i < n; i++) begin
        ba = a + 16'(i);
        exp_rd = exp_rd | (16'(ref_mem[ba]) << (8 * i));
      end

    @(negedge clk);
    ack_mode = mode; ack_dly = dly; log_q.delete();
    cpu_req = 1'b1; cpu_write_en = we; cpu_size = sz; cpu_addr = a; cpu_data_out = d;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      if (!hold) cpu_req = 1'b0;
      cyc++;
    end while (!cpu_ready && cyc < 200);
    check_eq("latency", cyc, lat);
    check_eq("error", cpu_error, to);
    check_eq("rdata", cpu_data_in, exp_rd);
    check_eq("en_in_done", mem_en, 0);
    check_eq("nbytes", log_q.size(), nexp);
    for (int i = 0; i < nexp && i < log_q.size(); i++) begin
      ba = a + 16'(i);
      sh = d >> (8 * i);
      eb = we ? sh[7:0] : ref_mem[ba];
      check_eq("byte_addr", log_q[i].a, ba);
      check_eq("byte_we", log_q[i].we, we);
      check_eq("byte_dat", log_q[i].d, eb);
    end

    @(negedge clk);
    check_eq("ready_pulse", cpu_ready, 0);
    check_eq("idle_en", mem_en, 0);
    check_eq("rdata_hold", cpu_data_in, exp_rd);
    check_eq("error_hold", cpu_error, to);
    if (hold) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("reaccept", mem_en, 1);
      cpu_req = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!cpu_ready && cyc < 200);
      check_eq("reaccept_done", cpu_ready, 1);
      @(negedge clk);
    end
    if (we && !to)
      for (int i = 0; i < n; i++) begin
        ba = a + 16'(i);
        sh = d >> (8 * i);
        ref_mem[ba] = sh[7:0];
      end
    cpu_write_en = 1'b0;
  endtask

  task automatic reset_mid_write();
    int cyc;
    @(negedge clk);
    ack_mode = 1; ack_dly = 2; log_q.delete();
    cpu_req = 1'b1; cpu_write_en = 1'b1; cpu_size = 2'b00;
    cpu_addr = 16'hFFFF; cpu_data_out = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 0;
    while (!(mem_en && mem_addr == 16'h0000) && cyc < 50) begin @(negedge clk); cyc++; end
    check_eq("rst_reach_wrap", {31'd0, mem_en && mem_addr == 16'h0000}, 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_en", mem_en, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_ready", cpu_ready, 0);
    check_eq("rst_error", cpu_error, 0);
    check_eq("rst_data", cpu_data_in, 0);
    reset = 1'b1;
    check_eq("rst_nbytes", log_q.size(), 1);
    check_eq("rst_byte0", bus_mem[16'hFFFF], 8'hFE);
    check_eq("rst_nowrap", bus_mem[16'h0000], ref_mem[16'h0000]);
    ref_mem[16'hFFFF] = 8'hFE;
    cpu_write_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[16'(i)] = init_byte(i);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_en", mem_en, 0);
    check_eq("reset_ready", cpu_ready, 0);
    check_eq("reset_error", cpu_error, 0);
    check_eq("reset_data", cpu_data_in, 0);
    check_eq("reset_addr", mem_addr, 0);
    check_eq("reset_wdata", mem_wdata, 0);
    reset = 1'b1;

    do_access(1'b1, 2'b00, 16'h0010, 16'hBEEF, 0, 0, 1'b0);
    do_access(1'b1, 2'b00, 16'h0020, 16'h1234, 0, 0, 1'b0);
    do_access(1'b0, 2'b00, 16'h0020, 16'h0000, 0, 0, 1'b0);
    do_access(1'b1, 2'b11, 16'h0003, 16'h77A5, 0, 0, 1'b0);
    do_access(1'b0, 2'b11, 16'h0003, 16'h0000, 0, 0, 1'b0);
    do_access(1'b1, 2'b00, 16'h0040, 16'h5A5A, 1, 2, 1'b1);
    do_access(1'b0, 2'b00, 16'h0050, 16'h0000, 2, 0, 1'b0);
    reset_mid_write();
    do_access(1'b0, 2'b00, 16'hFFFF, 16'h0000, 0, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [15:0] ra;
      int          md;
      ra = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 2)) : 16'($urandom);
      md = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, 16'($urandom),
                md, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
